// File: rtl/pool_max_if.sv
// Streaming pixel-in / window-max-out bus for pool_max.
// Signal names match the original flat port list.
interface pool_max_if #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 10
);
    logic                     in_start;
    logic                     in_valid;
    logic                     in_stop;
    logic signed [DWIDTH-1:0] in_data;
    logic        [LWIDTH-1:0] fea_size;
    logic        [LWIDTH-1:0] pool_size;
    logic                     out_start;
    logic                     out_valid;
    logic                     out_stop;
    logic signed [DWIDTH-1:0] out_data;
    logic                     busy;

    modport master (
        output in_start, in_valid, in_stop, in_data, fea_size, pool_size,
        input  out_start, out_valid, out_stop, out_data, busy
    );

    modport slave (
        input  in_start, in_valid, in_stop, in_data, fea_size, pool_size,
        output out_start, out_valid, out_stop, out_data, busy
    );
endinterface

// File: rtl/pool_max.sv
// Streaming non-overlapping k x k signed max pooling over a raster frame.
// Keeps a horizontal running max plus one row of per-window partial maxima.
module pool_max #(
    parameter int DWIDTH  = 16,
    parameter int LWIDTH  = 10,
    parameter int MAXFEA  = 256,
    parameter int MAXPOOL = 4
) (
    input logic        clk,
    input logic        xrst,
    pool_max_if.slave  bus
);
    localparam int AW = (MAXFEA > 1) ? $clog2(MAXFEA) : 1;

    typedef enum logic {S_WAIT, S_ACTIVE} state_t;

    state_t                   state;
    logic        [LWIDTH-1:0] fea_r;
    logic        [LWIDTH-1:0] k_r;
    logic        [LWIDTH-1:0] x;
    logic        [LWIDTH-1:0] y;
    logic        [LWIDTH-1:0] wx;
    logic        [LWIDTH-1:0] wy;
    logic        [AW-1:0]     ox;
    logic signed [DWIDTH-1:0] hmax;
    logic                     stop_pend;
    logic                     first_pend;
    logic signed [DWIDTH-1:0] pbuf [MAXFEA];

    logic                     accept;
    logic                     row_end;
    logic                     wx_last;
    logic                     wy_last;
    logic                     col_done;
    logic        [LWIDTH-1:0] k_in;
    logic signed [DWIDTH-1:0] h;
    logic signed [DWIDTH-1:0] pb_rd;
    logic signed [DWIDTH-1:0] pb_new;

    function automatic logic signed [DWIDTH-1:0] smax(
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        k_in = bus.pool_size;
        if (bus.pool_size == '0)
            k_in = LWIDTH'(1);
        else if (bus.pool_size > LWIDTH'(MAXPOOL))
            k_in = LWIDTH'(MAXPOOL);
    end

    assign accept   = (state == S_ACTIVE) && !stop_pend && bus.in_valid;
    assign row_end  = (x == fea_r - LWIDTH'(1));
    assign wx_last  = (wx == k_r - LWIDTH'(1));
    assign wy_last  = (wy == k_r - LWIDTH'(1));
    assign col_done = accept && wx_last;
    assign h        = (wx == '0) ? bus.in_data : smax(hmax, bus.in_data);
    assign pb_rd    = pbuf[ox];
    assign pb_new   = (wy == '0) ? h : smax(pb_rd, h);

    // Not reset: the wy==0 row overwrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (col_done)
            pbuf[ox] <= pb_new;
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state         <= S_WAIT;
            fea_r         <= '0;
            k_r           <= '0;
            x             <= '0;
            y             <= '0;
            wx            <= '0;
            wy            <= '0;
            ox            <= '0;
            hmax          <= '0;
            stop_pend     <= 1'b0;
            first_pend    <= 1'b0;
            bus.out_start <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_stop  <= 1'b0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.out_start <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_stop  <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (bus.in_start) begin
                        state      <= S_ACTIVE;
                        bus.busy   <= 1'b1;
                        fea_r      <= bus.fea_size;
                        k_r        <= k_in;
                        x          <= '0;
                        y          <= '0;
                        wx         <= '0;
                        wy         <= '0;
                        ox         <= '0;
                        hmax       <= '0;
                        stop_pend  <= 1'b0;
                        first_pend <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    // One extra cycle after the last pixel so busy falls after out_stop.
                    if (stop_pend) begin
                        state     <= S_WAIT;
                        bus.busy  <= 1'b0;
                        stop_pend <= 1'b0;
                    end else if (bus.in_valid) begin
                        hmax <= h;
                        if (row_end) begin
                            x  <= '0;
                            wx <= '0;
                            ox <= '0;
                            y  <= (y == fea_r - LWIDTH'(1)) ? '0 : y + LWIDTH'(1);
                            wy <= wy_last ? '0 : wy + LWIDTH'(1);
                        end else begin
                            x <= x + LWIDTH'(1);
                            if (wx_last) begin
                                wx <= '0;
                                ox <= ox + AW'(1);
                            end else begin
                                wx <= wx + LWIDTH'(1);
                            end
                        end
                        if (wx_last && wy_last) begin
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= pb_new;
                            bus.out_start <= first_pend;
                            first_pend    <= 1'b0;
                        end
                        if (bus.in_stop) begin
                            stop_pend    <= 1'b1;
                            bus.out_stop <= 1'b1;
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_max.sv
// Self-checking bench for pool_max: table-driven frames plus reset and random-stall sequences.
module tb_pool_max;
    localparam int DW = 16;
    localparam int LW = 10;

    logic clk = 1'b0;
    logic xrst;

    pool_max_if #(.DWIDTH(DW), .LWIDTH(LW)) bus();

    pool_max #(.DWIDTH(DW), .LWIDTH(LW), .MAXFEA(256), .MAXPOOL(4)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int got_q[$];
    int gcyc_q[$];
    int n_start, start_cyc, n_stop, stop_cyc;
    int pix[$];
    int exp_q[$];
    int pix_cyc[$];

    always @(negedge clk) begin
        if (bus.out_valid) begin
            got_q.push_back(int'(bus.out_data));
            gcyc_q.push_back(cyc);
        end
        if (bus.out_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (bus.out_stop) begin
            n_stop++;
            stop_cyc = cyc;
        end
    end

    typedef struct packed {
        int               fea;
        int               pool;
        int               d0;
        int               step;
        int               gap;
        int               glitch;
        int               use_lst;
        int               n;
        logic [0:3][15:0] lst;
        logic [0:8][15:0] ex;
    } vec_t;

    function automatic vec_t mk(input int fea, input int pool, input int d0, input int step,
                                input int gap, input int glitch, input int use_lst,
                                input logic [0:3][15:0] lst, input int n,
                                input logic [0:8][15:0] ex);
        vec_t v;
        v.fea = fea; v.pool = pool; v.d0 = d0; v.step = step; v.gap = gap;
        v.glitch = glitch; v.use_lst = use_lst; v.lst = lst; v.n = n; v.ex = ex;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic ref_model(input int fea, input int k);
        int nw, m, v;
        exp_q.delete();
        nw = fea / k;
        for (int r = 0; r < nw; r++)
            for (int c = 0; c < nw; c++) begin
                m = pix[(r * k) * fea + c * k];
                for (int dy = 0; dy < k; dy++)
                    for (int dx = 0; dx < k; dx++) begin
                        v = pix[(r * k + dy) * fea + c * k + dx];
                        if (v > m) m = v;
                    end
                exp_q.push_back(m);
            end
    endtask

    task automatic run_frame(input string nm, input int fea, input int pool,
                             input int gap, input int glitch);
        int k, nw, fall_cyc, last, r, c, idx;
        k  = (pool == 0) ? 1 : ((pool > 4) ? 4 : pool);
        nw = fea / k;
        got_q.delete(); gcyc_q.delete(); pix_cyc.delete();
        n_start = 0; n_stop = 0; start_cyc = -1; stop_cyc = -1;
        chk({nm, " busy_idle"}, int'(bus.busy), 0);
        bus.fea_size  = LW'(fea);
        bus.pool_size = LW'(pool);
        bus.in_start  = 1'b1;
        @(posedge clk); #1;
        bus.in_start  = 1'b0;
        bus.fea_size  = LW'(3);
        bus.pool_size = '0;
        chk({nm, " busy_rise"}, int'(bus.busy), 1);
        for (int i = 0; i < pix.size(); i++) begin
            while (int'($urandom_range(99)) < gap) begin
                bus.in_valid = 1'b0;
                bus.in_stop  = 1'($urandom_range(1));
                bus.in_data  = DW'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(pix[i]);
            bus.in_stop  = (i == pix.size() - 1);
            bus.in_start = (i == glitch);
            pix_cyc.push_back(cyc);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.in_stop  = 1'b0;
            bus.in_start = 1'b0;
        end
        fall_cyc = -1;
        for (int t = 0; t < 20; t++) begin
            if (!bus.busy) begin
                fall_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        last = pix_cyc[pix_cyc.size() - 1];
        chk({nm, " stop_count"}, n_stop, 1);
        chk({nm, " stop_cycle"}, stop_cyc, last + 1);
        chk({nm, " busy_fall_cycle"}, fall_cyc, last + 2);
        chk({nm, " out_count"}, got_q.size(), exp_q.size());
        chk({nm, " start_count"}, n_start, (exp_q.size() > 0) ? 1 : 0);
        if (exp_q.size() > 0 && got_q.size() > 0)
            chk({nm, " start_with_first"}, start_cyc, gcyc_q[0]);
        for (int j = 0; j < exp_q.size(); j++) begin
            r   = j / nw;
            c   = j % nw;
            idx = ((r + 1) * k - 1) * fea + (c + 1) * k - 1;
            if (j < got_q.size()) begin
                chk($sformatf("%s data[%0d]", nm, j), got_q[j], exp_q[j]);
                chk($sformatf("%s latency[%0d]", nm, j), gcyc_q[j], pix_cyc[idx] + 1);
            end
        end
        if (exp_q.size() > 0)
            chk({nm, " data_hold"}, int'(bus.out_data), exp_q[exp_q.size() - 1]);
    endtask

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(4, 2, 0, 1, 0, -1, 0, '0, 4,
                     {16'sd5, 16'sd7, 16'sd13, 16'sd15, 80'd0});
        vecs[1] = mk(5, 2, 0, 1, 0, -1, 0, '0, 4,
                     {16'sd6, 16'sd8, 16'sd16, 16'sd18, 80'd0});
        vecs[2] = mk(3, 1, 9, -1, 0, -1, 0, '0, 9,
                     {16'sd9, 16'sd8, 16'sd7, 16'sd6, 16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1});
        vecs[3] = mk(2, 2, 0, 0, 0, -1, 1, {-16'sd100, -16'sd3, -16'sd50, -16'sd7}, 1,
                     {-16'sd3, 128'd0});
        vecs[4] = mk(1, 0, -5, 0, 0, -1, 0, '0, 1,
                     {-16'sd5, 128'd0});
        vecs[5] = mk(4, 2, 0, 1, 30, 7, 0, '0, 4,
                     {16'sd5, 16'sd7, 16'sd13, 16'sd15, 80'd0});
        vecs[6] = mk(4, 3, 0, 1, 20, -1, 0, '0, 1,
                     {16'sd10, 128'd0});
        vecs[7] = mk(2, 3, 1, 1, 0, -1, 0, '0, 0, '0);

        bus.in_start  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_stop   = 1'b0;
        bus.in_data   = '0;
        bus.fea_size  = '0;
        bus.pool_size = '0;
        xrst = 1'b1;
        #1;
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out_start", int'(bus.out_start), 0);
        chk("reset out_stop", int'(bus.out_stop), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset out_data", int'(bus.out_data), 0);
        repeat (2) @(posedge clk);
        #1 xrst = 1'b0;

        // Mid-frame reset after 6 pixels of a 4x4/k=2 frame.
        bus.fea_size  = LW'(4);
        bus.pool_size = LW'(2);
        bus.in_start  = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("pre_reset out_valid", int'(bus.out_valid), 1);
        chk("pre_reset out_data", int'(bus.out_data), 5);
        #2 xrst = 1'b1;
        #1;
        chk("midreset out_valid", int'(bus.out_valid), 0);
        chk("midreset out_data", int'(bus.out_data), 0);
        chk("midreset busy", int'(bus.busy), 0);
        @(posedge clk); #1 xrst = 1'b0;
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_stop  = 1'b1;
            bus.in_data  = DW'(100);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_stop  = 1'b0;
        @(posedge clk); #1;
        chk("wait_ignores_valid outputs", got_q.size(), 0);
        chk("wait_ignores_valid busy", int'(bus.busy), 0);

        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(i);
        exp_q = '{5, 7, 13, 15};
        run_frame("after_reset", 4, 2, 0, -1);

        // Table frames run back-to-back: each starts the cycle busy falls.
        for (int v = 0; v < 8; v++) begin
            pix.delete();
            for (int i = 0; i < vecs[v].fea * vecs[v].fea; i++) begin
                if (vecs[v].use_lst != 0)
                    pix.push_back(int'($signed(vecs[v].lst[i])));
                else
                    pix.push_back(vecs[v].d0 + vecs[v].step * i);
            end
            exp_q.delete();
            for (int j = 0; j < vecs[v].n; j++)
                exp_q.push_back(int'($signed(vecs[v].ex[j])));
            run_frame($sformatf("vec%0d", v), vecs[v].fea, vecs[v].pool,
                      vecs[v].gap, vecs[v].glitch);
        end

        pix.delete();
        for (int i = 0; i < 36; i++) pix.push_back(int'($urandom_range(65535)) - 32768);
        ref_model(6, 3);
        run_frame("rand_6x6_k3", 6, 3, 40, -1);

        pix.delete();
        for (int i = 0; i < 64; i++) pix.push_back(int'($urandom_range(65535)) - 32768);
        ref_model(8, 4);
        run_frame("rand_8x8_k7", 8, 7, 25, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool_max.md
# pool_max

Streaming max-pooling datapath that sits directly downstream of the pooling controller. It consumes one raster-ordered feature map per frame (one pixel per `in_valid` cycle) and emits the signed maximum of every non-overlapping `pool_size` x `pool_size` window, with start/valid/stop sideband. It keeps only a horizontal running max and a one-row buffer of per-window partial maxima, so it needs no full-frame storage.

## Interface
- `DWIDTH`, 16: signed feature width.
- `LWIDTH`, 10: size/counter width.
- `MAXFEA`, 256: maximum `fea_size`; the partial-max buffer holds `MAXFEA` entries.
- `MAXPOOL`, 4: maximum window size.

- `clk`  in  1  clock; all logic on rising edge.
- `xrst`  in  1  reset: asynchronous, active-high (`xrst`=1 resets).
- `in_start`  in  1  frame start pulse; latches config.
- `in_valid`  in  1  `in_data` holds a pixel.
- `in_stop`  in  1  marks the last pixel of the frame; qualified by `in_valid`.
- `in_data`  in  DWIDTH  signed pixel.
- `fea_size`  in  LWIDTH  frame width = height; sampled on accepted `in_start`.
- `pool_size`  in  LWIDTH  window size k; sampled on accepted `in_start`.
- `out_start`  out  1  pulse with the first output of the frame.
- `out_valid`  out  1  `out_data` valid.
- `out_stop`  out  1  frame-done pulse.
- `out_data`  out  DWIDTH  signed window max.
- `busy`  out  1  high in S_ACTIVE.

## Operation
- **States:** S_WAIT, S_ACTIVE.
  - S_WAIT -> S_ACTIVE on `in_start`. This latches `fea_size` and k.
  - k=0 is treated as 1. k>MAXPOOL is treated as MAXPOOL.
  - S_ACTIVE -> S_WAIT on the cycle after `in_valid && in_stop`.
- **Ignored inputs:**
  - `in_valid` in S_WAIT is ignored.
  - `in_start` in S_ACTIVE is ignored.
  - `in_stop` without `in_valid` is ignored.
- **Counters:** x, y (0..fea_size-1), wx = x mod k, wy = y mod k, and output column ox. All advance only on `in_valid`.
  - At end of row: x, wx and ox clear; y and wy advance.
  - All counters clear on entry to S_ACTIVE.
- **Horizontal max:** on `wx==0`, `hmax<=in_data`; otherwise `hmax<=max(hmax,in_data)`.
- **Window column complete (`wx==k-1`):** let h = max(hmax, in_data), or h = in_data when k=1.
  - If `wy==0`: `pbuf[ox]<=h`. Otherwise `pbuf[ox]<=max(pbuf[ox],h)`.
  - If `wy==k-1`: emit max(pbuf[ox],h), or h when wy==0.
  - ox increments.
- **Partial windows are dropped (floor semantics):**
  - Trailing columns with x ≥ floor(fea_size/k)·k never reach `wx==k-1`.
  - Trailing rows never reach `wy==k-1`.
  - Frame output is floor(fea_size/k)² pixels.
- **Arithmetic:** all comparisons are signed two's-complement over DWIDTH; no width growth.
- **Buffer:** `pbuf` is a register array, read asynchronously. Each entry is touched at most once per row, so no read/write collision exists.

## Timing
- **Reset values:** `out_start`, `out_valid`, `out_stop`, `busy` = 0; `out_data` = 0; state S_WAIT; all counters and `hmax` 0. `pbuf` is not reset; row wy=0 overwrites it before any read.
- **Latency:** `out_valid`/`out_data` are registered 1 cycle after the `in_valid` that completes a window.
- **`out_data`:** holds its last value while `out_valid`=0.
- **`out_start`:** coincides with the first `out_valid` of the frame. If the frame produces no outputs (fea_size<k), `out_start` never fires.
- **`out_stop`:** fires 1 cycle after the accepted `in_stop`.
  - If fea_size is a multiple of k, it coincides with the last `out_valid`.
  - Otherwise it is a standalone pulse.
- **`busy`:** rises the cycle after `in_start` and falls the cycle after `out_stop`.
- **Next frame:** `in_start` is accepted again from the cycle `busy` falls.
- **Stalls:** gaps in `in_valid` stall all counters; there is no timeout.
- **Mid-frame reset:** asserting `xrst` immediately forces all outputs to 0 and the state to S_WAIT. After release, only a new `in_start` restarts the block.

## Test plan
- **Divisible frame:** 4x4, k=2, in_data raster 0..15 contiguous.
  - Outputs 5, 7, 13, 15, each 1 cycle after pixels 5, 7, 13, 15.
  - `out_start` with 5; `out_stop` with 15; `busy` low the next cycle.
- **Non-divisible frame:** 5x5, k=2, data 0..24.
  - Exactly 4 outputs: 6, 8, 16, 18.
  - `out_stop` is a standalone pulse 1 cycle after pixel 24.
- **Pass-through:** k=1, 3x3, data 9..1.
  - Output equals input, latency 1, 9 outputs.
  - `out_start` on the first output, `out_stop` on the last.
- **Signed compare:** k=2, 2x2, data -100, -3, -50, -7 → single output -3. Also k=0 with data {-5} on a 1x1 frame → output -5.
- **Stall and k clamp:** 6x6, k=3, random `in_valid` gaps, data random signed → 4 outputs matching the reference max model. Repeat with pool_size=7 (clamped to 4) on an 8x8 frame → 4 outputs.
- **Reset and restart:**
  - Assert `xrst` after 6 pixels of a 4x4/k=2 frame → outputs 0, `busy` 0.
  - Then `in_start` plus a clean 4x4 frame → correct 5, 7, 13, 15.
  - An extra `in_start` mid-frame is ignored.
  - Back-to-back frames with `in_start` on the cycle `busy` falls both produce correct outputs.
